// File: rtl/sub_shift_rows.sv
// AES-128 SubBytes followed by ShiftRows on a 128-bit column-major state, valid/ready on both sides.
// Define SUB_SHIFT_PARALLEL_EN for a single-cycle 16-S-box datapath; default is 4 S-boxes over 4 cycles.
module sub_shift_rows (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);

   typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

   // Byte b lives at bits [2047-8*b -: 8].
   localparam logic [2047:0] SboxTable = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] idx;
      idx = 11'd2047 - {b, 3'b000};
      return SboxTable[idx -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   state_e       st_q, st_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [127:0] data_q, data_d;

`ifdef SUB_SHIFT_PARALLEL_EN
   logic [127:0] data_sub;

   always_comb begin
      data_sub = {sub_word(state_in[127:96]), sub_word(state_in[95:64]),
                  sub_word(state_in[63:32]),  sub_word(state_in[31:0])};
   end

   always_comb begin
      st_d   = st_q;
      cnt_d  = 2'd0;
      data_d = data_q;
      unique case (st_q)
         StIdle: begin
            if (in_valid) begin
               data_d = data_sub;
               st_d   = StDone;
            end
         end
         StDone: begin
            if (out_ready) st_d = StIdle;
         end
         default: st_d = StIdle;
      endcase
   end
`else
   logic [31:0] col_in, col_sub;

   always_comb begin
      unique case (cnt_q)
         2'd0:    col_in = data_q[127:96];
         2'd1:    col_in = data_q[95:64];
         2'd2:    col_in = data_q[63:32];
         default: col_in = data_q[31:0];
      endcase
      col_sub = sub_word(col_in);
   end

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      data_d = data_q;
      unique case (st_q)
         StIdle: begin
            if (in_valid) begin
               data_d = state_in;
               cnt_d  = 2'd0;
               st_d   = StSub;
            end
         end
         StSub: begin
            // Column cnt is substituted in place; the counter wraps back to 0 after column 3.
            unique case (cnt_q)
               2'd0:    data_d[127:96] = col_sub;
               2'd1:    data_d[95:64]  = col_sub;
               2'd2:    data_d[63:32]  = col_sub;
               default: data_d[31:0]   = col_sub;
            endcase
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) st_d = StDone;
         end
         StDone: begin
            if (out_ready) st_d = StIdle;
         end
         default: st_d = StIdle;
      endcase
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= StIdle;
         cnt_q  <= 2'd0;
         data_q <= 128'h0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         data_q <= data_d;
      end
   end

   // ShiftRows is pure wiring: out(r,c) = reg(r,(c+r) mod 4).
   always_comb begin
      state_out = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            state_out[127 - 8*(4*c + r) -: 8] = data_q[127 - 8*(4*((c + r) % 4) + r) -: 8];
         end
      end
   end

   always_comb begin
      in_ready  = (st_q == StIdle);
      out_valid = (st_q == StDone);
      busy      = (st_q != StIdle);
   end

endmodule

// File: tb/tb_sub_shift_rows.sv
// Directed self-checking bench for sub_shift_rows: FIPS-197 vectors, backpressure, reset, back-to-back.
module tb_sub_shift_rows;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] state_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] state_out;
   logic         busy;

   int n_cmp = 0;
   int n_err = 0;

`ifdef SUB_SHIFT_PARALLEL_EN
   localparam int ExpLat = 1;
`else
   localparam int ExpLat = 4;
`endif

   localparam logic [127:0] FipsIn   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FipsOut  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] FipsMix  = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] SeqIn    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] SeqOut   = 128'h636b6776f201ab7b30d777c5fe7c6f2b;
   localparam logic [127:0] ZeroOut  = {16{8'h63}};
   localparam logic [127:0] OnesOut  = {16{8'h16}};

   sub_shift_rows dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state_in  (state_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_out (state_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   // Offers one state, then waits (bounded) until out_valid is seen on a falling edge.
   // Leaves the handshake to the caller; lat is edges counted after the accept edge.
   task automatic run_block(input logic [127:0] din, output logic [127:0] dout, output int lat);
      @(negedge clk);
      state_in = din;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat  = 0;
      dout = 'x;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid) begin
            dout = state_out;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                  in_ready, out_valid, busy);
      end
      @(negedge clk);
      rst_n    = 1'b1;
      state_in = 128'h0;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL reset_first_accept: busy=%b, want 1", busy);
      end
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || state_out !== ZeroOut) begin
         n_err++;
         $display("FAIL reset_first_result: valid=%b out=%h, want 1 %h", out_valid, state_out,
                  ZeroOut);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_fips;
      logic [127:0] d;
      int lat;
      run_block(FipsIn, d, lat);
      n_cmp++;
      if (lat !== ExpLat) begin
         n_err++;
         $display("FAIL fips_latency: got %0d, want %0d", lat, ExpLat);
      end
      n_cmp++;
      if (d !== FipsOut) begin
         n_err++;
         $display("FAIL fips_result: got %h, want %h", d, FipsOut);
      end
      n_cmp++;
      if (mix_columns(d) !== FipsMix) begin
         n_err++;
         $display("FAIL fips_mixcol: got %h, want %h", mix_columns(d), FipsMix);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL fips_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_patterns;
      logic [127:0] vin  [3];
      logic [127:0] vexp [3];
      logic [127:0] d;
      int lat;
      vin[0] = 128'h0;          vexp[0] = ZeroOut;
      vin[1] = {128{1'b1}};     vexp[1] = OnesOut;
      vin[2] = SeqIn;           vexp[2] = SeqOut;
      for (int k = 0; k < 3; k++) begin
         run_block(vin[k], d, lat);
         n_cmp++;
         if (d !== vexp[k] || lat !== ExpLat) begin
            n_err++;
            $display("FAIL pattern_%0d: got %h lat %0d, want %h lat %0d", k, d, lat, vexp[k],
                     ExpLat);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_backpressure;
      logic [127:0] d;
      int lat;
      out_ready = 1'b0;
      run_block(SeqIn, d, lat);
      state_in = FipsIn;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_out !== SeqOut) begin
            n_err++;
            $display("FAIL bp_hold_%0d: valid=%b ready=%b out=%h, want 1 0 %h", i, out_valid,
                     in_ready, state_out, SeqOut);
         end
      end
      // Handshake edge with in_valid still high: that offer must not be taken.
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL bp_release: valid=%b ready=%b busy=%b, want 0 1 0", out_valid, in_ready,
                  busy);
      end
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL bp_no_dup: valid=%b busy=%b, want 0 0", out_valid, busy);
      end
   endtask

   task automatic test_reset_mid_sub;
      bit stray;
      logic [127:0] d;
      int lat;
      @(negedge clk);
      state_in = FipsIn;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL midsub_reset: valid=%b ready=%b busy=%b, want 0 1 0", out_valid,
                  in_ready, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      stray = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) stray = 1'b1;
      end
      n_cmp++;
      if (stray) begin
         n_err++;
         $display("FAIL midsub_stale_valid: out_valid pulsed after reset, want none");
      end
      run_block(128'h0, d, lat);
      n_cmp++;
      if (d !== ZeroOut || lat !== ExpLat) begin
         n_err++;
         $display("FAIL midsub_new_block: got %h lat %0d, want %h lat %0d", d, lat, ZeroOut,
                  ExpLat);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      int acc_at [2];
      logic [127:0] outs [2];
      int n_acc, n_out;
      bit take, give;
      n_acc = 0;
      n_out = 0;
      out_ready = 1'b1;
      @(negedge clk);
      state_in = FipsIn;
      in_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (i > 0) @(negedge clk);
         give = out_valid && out_ready;
         take = in_valid && in_ready;
         if (give) begin
            if (n_out < 2) outs[n_out] = state_out;
            n_out++;
         end
         if (take) begin
            if (n_acc < 2) acc_at[n_acc] = i;
            n_acc++;
         end
         @(posedge clk);
         #1;
         if (take && n_acc == 1) state_in = SeqIn;
         if (take && n_acc == 2) in_valid = 1'b0;
      end
      n_cmp++;
      if (n_acc !== 2 || n_out !== 2) begin
         n_err++;
         $display("FAIL b2b_counts: accepts=%0d outputs=%0d, want 2 2", n_acc, n_out);
      end else begin
         n_cmp++;
         if (acc_at[1] - acc_at[0] !== ExpLat + 2) begin
            n_err++;
            $display("FAIL b2b_interval: got %0d, want %0d", acc_at[1] - acc_at[0], ExpLat + 2);
         end
         n_cmp++;
         if (outs[0] !== FipsOut || outs[1] !== SeqOut) begin
            n_err++;
            $display("FAIL b2b_results: got %h %h, want %h %h", outs[0], outs[1], FipsOut,
                     SeqOut);
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      state_in  = 128'h0;
      test_reset();
      test_fips();
      test_patterns();
      test_backpressure();
      test_reset_mid_sub();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sub_shift_rows.md
SUB_SHIFT_ROWS -- requirements
Module: sub_shift_rows

Interface
REQ-001 Parameters: none; all widths are fixed by AES-128.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream offers state_in this cycle.
REQ-005 in_ready  output  1  block can accept a state this cycle.
REQ-006 state_in  input  128  AES state, column-major: [127:120]=s(r0,c0), [119:112]=s(r1,c0), ... [7:0]=s(r3,c3).
REQ-007 out_valid  output  1  state_out holds a finished result.
REQ-008 out_ready  input  1  downstream (mix_columns input register) accepts state_out.
REQ-009 state_out  output  128  ShiftRows(SubBytes(state_in)), same column-major byte order as state_in.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 The block SHALL apply the FIPS-197 forward S-box to all 16 bytes, then ShiftRows: out(r,c) = sub(r,(c+r) mod 4).
REQ-012 FSM states: IDLE, SUB, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 IDLE: on in_valid&&in_ready, state_in is captured into the state register, the column counter is cleared to 0, and the FSM moves to SUB; otherwise it stays in IDLE.
REQ-014 SUB: each cycle, substitute the 4 bytes of column cnt (bits [127-32*cnt -: 32]) in place using 4 shared S-box instances, then increment cnt.
REQ-015 The 2-bit column counter SHALL wrap from 3 to 0; when cnt==3 is processed, the FSM moves to DONE.
REQ-016 Latency: accept on edge k -> out_valid high after edge k+4; state_out is ShiftRows wiring of the register, with no extra register stage.
REQ-017 DONE: state_out and out_valid SHALL hold stable until out_valid&&out_ready; on that edge the FSM moves to IDLE.
REQ-018 No overlap: in_valid is ignored outside IDLE; the minimum accept-to-accept interval with out_ready=1 is 6 cycles.
REQ-019 in_valid asserted in the same cycle as the DONE handshake SHALL NOT be accepted; it is accepted no earlier than the following cycle, in IDLE.
REQ-020 state_out outside DONE is don't-care for consumers; the bench SHALL check it only while out_valid=1.

Reset
REQ-021 rst_n low SHALL asynchronously force: FSM=IDLE, cnt=0, state register=128'h0, out_valid=0, busy=0; in_ready=1 follows combinationally from IDLE.
REQ-022 Reset asserted mid-SUB or in DONE SHALL discard the in-flight state; no out_valid pulse follows reset release.
REQ-023 On the first rising edge after rst_n deasserts, the block SHALL be able to accept.

Configuration
REQ-024 Macro SUB_SHIFT_PARALLEL_EN: when defined, 16 S-box instances substitute the whole state at capture and IDLE goes directly to DONE; latency is 1 cycle (out_valid after edge k+1); SUB is unreachable.
REQ-025 Without SUB_SHIFT_PARALLEL_EN, the 4-S-box serial datapath of REQ-014..REQ-016 applies; the interface and results are identical in both builds.

Verification
REQ-026 FIPS-197 App. B round 1: state_in=193de3bea0f4e22b9ac68d2ae9f84808 -> state_out=d4bf5d30e0b452aeb84111f11e2798e5, out_valid 4 cycles after accept (1 cycle if PARALLEL).
REQ-027 Chained with mix_columns: state_in from REQ-026 -> mix_columns output 046681e5e0cb199a48f8d37a2806264c.
REQ-028 state_in=128'h0 -> state_out=6363...63 (16 bytes); state_in=all ff -> all 16 bytes 16.
REQ-029 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, state_out stable, in_ready=0, second in_valid ignored; release -> one transfer, then IDLE.
REQ-030 Reset: assert rst_n=0 with cnt==2 in SUB -> out_valid=0, in_ready=1 immediately; after release, new input 0 -> 6363...63, no stale result.
REQ-031 Back-to-back: in_valid and out_ready held at 1 for two blocks -> accepts 6 cycles apart, both results correct, no drop or duplicate.
